// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin sharing of one iterative cordic engine between N requesters
module cordic_arbiter #(
    parameter int N          = 4,
    parameter int ID_W       = 2,
    parameter int ENG_CYCLES = 33
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    input  logic [32*N-1:0]   req_angle,
    output logic [N-1:0]      req_ready,
    output logic              eng_start,
    output logic [31:0]       eng_angle,
    input  logic [31:0]       eng_cos,
    input  logic [31:0]       eng_sin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [31:0]       rsp_cos,
    output logic [31:0]       rsp_sin,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    // The engine has no done flag; its outputs are final ENG_CYCLES after the
    // start cycle, so the capture edge closes the WAIT cycle where the count reaches this.
    localparam logic [5:0] CAP_CNT = 6'(ENG_CYCLES);

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [5:0]      wait_cnt;
    logic            grant_found;
    logic [ID_W-1:0] grant;
    logic [ID_W:0]   search_idx;
    logic [ID_W:0]   ptr_inc;
    logic [31:0]     grant_angle;

    // Rotating priority search: first valid requester at or after rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        search_idx  = '0;
        for (int k = 0; k < N; k++) begin
            search_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (search_idx >= (ID_W+1)'(N)) begin
                search_idx = search_idx - (ID_W+1)'(N);
            end
            for (int j = 0; j < N; j++) begin
                if (!grant_found && search_idx == (ID_W+1)'(j) && req_valid[j]) begin
                    grant_found = 1'b1;
                    grant       = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        grant_angle = '0;
        for (int j = 0; j < N; j++) begin
            if (grant == ID_W'(j)) begin
                grant_angle = req_angle[32*j +: 32];
            end
        end
    end

    assign ptr_inc = {1'b0, grant} + (ID_W+1)'(1);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        eng_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (grant_found && !reset) begin
                    req_ready = N'(1) << grant;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                eng_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == CAP_CNT) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            wait_cnt  <= '0;
            eng_angle <= '0;
            rsp_id    <= '0;
            rsp_cos   <= '0;
            rsp_sin   <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (state_nxt == S_START) begin
                        eng_angle <= grant_angle;
                        rsp_id    <= grant;
                        rr_ptr    <= (ptr_inc >= (ID_W+1)'(N)) ? '0 : ptr_inc[ID_W-1:0];
                    end
                end
                S_START: wait_cnt <= 6'd1;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 6'd1;
                    if (wait_cnt == CAP_CNT) begin
                        rsp_cos <= eng_cos;
                        rsp_sin <= eng_sin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - directed bench for cordic_arbiter with a latency-exact engine model
module tb_cordic_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [127:0] req_angle;
    logic [3:0]  req_ready;
    logic        eng_start;
    logic [31:0] eng_angle;
    logic [31:0] eng_cos;
    logic [31:0] eng_sin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_cos;
    logic [31:0] rsp_sin;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int cyc;
    int acc;
    int bad;
    logic [31:0] angles [4];

    always #5 clock = ~clock;

    cordic_arbiter #(.N(4), .ID_W(2), .ENG_CYCLES(33)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .eng_start (eng_start),
        .eng_angle (eng_angle),
        .eng_cos   (eng_cos),
        .eng_sin   (eng_sin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_cos   (rsp_cos),
        .rsp_sin   (rsp_sin),
        .busy      (busy)
    );

    function automatic logic [31:0] cos_of(input logic [31:0] a);
        if (a == 32'h0000_0000)      return 32'h4000_0000;
        else if (a == 32'h3243_F6A9) return 32'h2D41_3CCD;
        else                         return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] sin_of(input logic [31:0] a);
        if (a == 32'h0000_0000)      return 32'h0000_0000;
        else if (a == 32'h3243_F6A9) return 32'h2D41_3CCD;
        else                         return ~a;
    endfunction

    // Engine: loads on start, iterates 32 edges, shows junk until final.
    logic [31:0] eng_a;
    int          eng_cnt;
    logic        eng_loaded;
    always @(posedge clock) begin
        if (reset) begin
            eng_cnt    <= 0;
            eng_loaded <= 1'b0;
            eng_a      <= '0;
        end else if (eng_start) begin
            eng_a      <= eng_angle;
            eng_cnt    <= 32;
            eng_loaded <= 1'b1;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
        end
    end
    assign eng_cos = (eng_loaded && eng_cnt == 0) ? cos_of(eng_a) : 32'hDEAD_BEEF;
    assign eng_sin = (eng_loaded && eng_cnt == 0) ? sin_of(eng_a) : 32'hBAD0_C0DE;

    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    // Entered just after the edge starting the accept cycle, with requests driven.
    task automatic serve(input int id, input logic [3:0] add_after, input int hold, output int acc_cyc);
        logic [31:0] ang, ec, es;
        logic [3:0]  oh;
        int          nbad;
        ang = angles[id];
        ec  = cos_of(ang);
        es  = sin_of(ang);
        oh  = 4'b0001 << id;
        rsp_ready = (hold == 0);
        @(negedge clock);
        check("accept_ready", req_ready, oh);
        check("accept_busy", busy, 0);
        acc_cyc = cyc;
        @(posedge clock); #1;
        req_valid[id] = 1'b0;
        req_valid = req_valid | add_after;
        @(negedge clock);
        check("start_pulse", eng_start, 1);
        check("start_angle", eng_angle, ang);
        check("start_ready", req_ready, 0);
        nbad = 0;
        for (int k = 2; k <= 34; k++) begin
            @(negedge clock);
            if (eng_start || rsp_valid || req_ready != 4'b0 || !busy) nbad++;
        end
        check("wait_quiet", nbad, 0);
        @(negedge clock);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_cos", rsp_cos, ec);
        check("rsp_sin", rsp_sin, es);
        if (hold > 0) begin
            nbad = 0;
            for (int k = 0; k < hold; k++) begin
                if (k > 0) @(negedge clock);
                if (!rsp_valid || rsp_id != 2'(id) || rsp_cos != ec || rsp_sin != es
                    || !busy || req_ready != 4'b0 || eng_start) nbad++;
            end
            check("hold_stable", nbad, 0);
            @(posedge clock); #1;
            rsp_ready = 1'b1;
            @(negedge clock);
            check("hold_release", rsp_valid, 1);
        end
        @(posedge clock); #1;
        check("idle_after", busy, 0);
        check("rsp_dropped", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        angles[0] = 32'h1111_1111;
        angles[1] = 32'h0000_0000;
        angles[2] = 32'h3243_F6A9;
        angles[3] = 32'h7654_3210;
        req_angle = {angles[3], angles[2], angles[1], angles[0]};
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        reset     = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_eng_angle", eng_angle, 0);
        check("rst_rsp_cos", rsp_cos, 0);
        reset = 1'b0;

        // All four from reset: order 0,1,2,3 every 36 cycles.
        for (int i = 0; i < 4; i++) begin
            serve(i, 4'b0000, 0, acc);
            check("acc_cycle", acc, 36 * i);
        end

        // Fairness: 0 and 3 raised right after granting 2; 3 must win.
        req_valid = 4'b0100;
        serve(2, 4'b1001, 0, acc);
        serve(3, 4'b0000, 0, acc);
        serve(0, 4'b0000, 0, acc);

        // Back-pressure with another requester waiting.
        req_valid = 4'b0010;
        serve(1, 4'b0100, 10, acc);
        serve(2, 4'b0000, 0, acc);

        // Reset mid-WAIT at wait_cnt=10 (cycle A+11).
        req_valid = 4'b1000;
        @(negedge clock);
        check("rw_accept", req_ready, 4'b1000);
        @(posedge clock); #1;
        req_valid = 4'b0000;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("rw_busy", busy, 0);
        check("rw_rsp_valid", rsp_valid, 0);
        check("rw_eng_start", eng_start, 0);
        check("rw_eng_angle", eng_angle, 0);
        check("rw_rsp_id", rsp_id, 0);
        check("rw_rsp_cos", rsp_cos, 0);
        check("rw_rsp_sin", rsp_sin, 0);
        check("rw_ready", req_ready, 0);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (rsp_valid || busy || eng_start) bad++;
        end
        check("rw_no_orphan", bad, 0);
        @(posedge clock); #1;

        // Pointer back at 0 after reset: 1 beats 3.
        req_valid = 4'b1010;
        serve(1, 4'b0000, 0, acc);
        serve(3, 4'b0000, 0, acc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
